// File: rtl/ic_dma_rd_pkg.sv
// Shared types and AXI constants for the icache DMA read responder.
// The IC_DMA_TIMEOUT_EN build makes the ST_DRAIN state reachable.
package ic_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_ACK,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    localparam logic [7:0]  ARLEN_SINGLE = 8'd0;
    localparam logic [2:0]  ARSIZE_16B   = 3'b100;
    localparam logic [1:0]  ARBURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    // Clears the byte offset within a 16-byte line; truncated to the address width at use
    localparam logic [63:0] LINE_MASK    = ~64'hF;

endpackage

// File: rtl/ic_dma_rd_if.sv
// Request and AXI read-channel bundle for ic_dma_rd.
// slave = the responder's view, master = the requester/interconnect view.
interface ic_dma_rd_if #(
    parameter int unsigned ADDR_W = 33,
    parameter int unsigned DATA_W = 128
);
    logic [ADDR_W-1:0] req_addr;
    logic              req_valid;
    logic              req_ack;
    logic [DATA_W-1:0] req_data;

    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport slave (
        input  req_addr, req_valid,
        output req_ack, req_data,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport master (
        output req_addr, req_valid,
        input  req_ack, req_data,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/ic_dma_rd_wdog.sv
// Loadable down-counting watchdog for the R-channel wait of ic_dma_rd.
// Only instantiated when IC_DMA_TIMEOUT_EN is defined.
module ic_dma_wdog #(
    parameter int unsigned LIMIT_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [LIMIT_W-1:0] limit,
    output logic               expire
);

    logic [LIMIT_W-1:0] cnt_q;

    // Reloaded while idle so the first enabled cycle sees the full limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= limit;
        end else if (en && !expire) begin
            cnt_q <= cnt_q - LIMIT_W'(1);
        end
    end

    assign expire = en && (cnt_q <= LIMIT_W'(1));

endmodule

// File: rtl/ic_dma_rd.sv
// Single-beat AXI4 read responder for icache line requests.
// Define IC_DMA_TIMEOUT_EN to add the R-channel watchdog and DRAIN recovery.
module ic_dma_rd
    import ic_dma_pkg::*;
#(
    parameter int unsigned ADDR_W         = 33,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    ic_dma_rd_if.slave  bus,
    output logic        busy,
    output logic [15:0] err_cnt
);

    state_t              state_q, state_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [15:0]         err_q, err_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                ar_hs, r_hs, tmo;
    logic                r_beat, r_tmo, aborting;

    assign ar_hs    = arvalid_q & bus.m_axi_arready;
    assign r_hs     = rready_q & bus.m_axi_rvalid;
    assign r_beat   = (state_q == ST_R) && r_hs;
    assign r_tmo    = (state_q == ST_R) && !r_hs && tmo;
    assign aborting = abort_q | stop;

`ifdef IC_DMA_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    ic_dma_wdog #(.LIMIT_W(TMO_W)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != ST_R),
        .en     (state_q == ST_R),
        .limit  (TMO_W'(TIMEOUT_CYCLES)),
        .expire (tmo)
    );
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            abort_q   <= 1'b0;
            araddr_q  <= '0;
            data_q    <= '0;
            err_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            abort_q   <= abort_d;
            araddr_q  <= araddr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = ST_AR;
            end
            ST_AR: begin
                if (stop)  abort_d = 1'b1;
                if (ar_hs) state_d = ST_R;
            end
            ST_R: begin
                if (stop) abort_d = 1'b1;
                if (r_hs) begin
                    state_d = aborting ? ST_HOLD : ST_ACK;
                    abort_d = 1'b0;
                end else if (tmo) begin
                    state_d = ST_DRAIN;
                    abort_d = 1'b0;
                end
            end
            ST_ACK:   state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_IDLE;
            ST_DRAIN: begin
                if (r_hs && bus.m_axi_rlast) state_d = ST_HOLD;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so nothing
    // combinational reaches the ports.
    always_comb begin
        arvalid_d = (state_d == ST_AR);
        rready_d  = (state_d == ST_R) || (state_d == ST_DRAIN);
        busy_d    = (state_d != ST_IDLE);
        ack_d     = (state_d == ST_ACK) || (r_tmo && !aborting);

        araddr_d = araddr_q;
        if ((state_q == ST_IDLE) && bus.req_valid) begin
            araddr_d = bus.req_addr & ADDR_W'(LINE_MASK);
        end

        data_d = data_q;
        if (r_beat && !aborting) begin
            data_d = bus.m_axi_rdata;
        end else if (r_tmo && !aborting) begin
            data_d = '0;
        end

        err_d = err_q;
        if (((r_beat && (bus.m_axi_rresp != RESP_OKAY)) || r_tmo) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = ARLEN_SINGLE;
    assign bus.m_axi_arsize  = ARSIZE_16B;
    assign bus.m_axi_arburst = ARBURST_INCR;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.req_ack       = ack_q;
    assign bus.req_data      = data_q;
    assign busy              = busy_q;
    assign err_cnt           = err_q;

endmodule

// File: tb/tb_ic_dma_rd.sv
// Directed self-checking bench for ic_dma_rd; the timeout scenario
// depends on whether IC_DMA_TIMEOUT_EN is defined.
module tb_ic_dma_rd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic [15:0] err_cnt;

    ic_dma_rd_if #(.ADDR_W(33), .DATA_W(128)) bus ();

    ic_dma_rd #(.ADDR_W(33), .DATA_W(128), .TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stop    (stop),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          ack_cnt  = 0;
    int          ar_cnt   = 0;
    int          mono_bad = 0;
    logic [32:0] last_ar  = '0;

    // Handshake monitor; all addresses issued in this run are strictly increasing
    always @(negedge clk) begin
        if (bus.req_ack) ack_cnt++;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            if (ar_cnt > 0 && bus.m_axi_araddr <= last_ar) mono_bad++;
            last_ar = bus.m_axi_araddr;
            ar_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [32:0] addr, input logic [32:0] exp_ar,
                      input logic [127:0] data, input logic [1:0] resp,
                      input int ar_wait, input int r_wait, input bit keep_vld);
        bus.req_addr  = addr;
        bus.req_valid = 1'b1;
        step();
        check("arvalid", bus.m_axi_arvalid, 1);
        check("araddr", bus.m_axi_araddr, exp_ar);
        for (int i = 0; i < ar_wait; i++) begin
            check("ar_hold_vld", bus.m_axi_arvalid, 1);
            check("ar_hold_addr", bus.m_axi_araddr, exp_ar);
            check("ar_no_ack", bus.req_ack, 0);
            step();
        end
        bus.m_axi_arready = 1'b1;
        step();
        bus.m_axi_arready = 1'b0;
        check("rready", bus.m_axi_rready, 1);
        check("arvalid_off", bus.m_axi_arvalid, 0);
        for (int i = 0; i < r_wait; i++) begin
            check("r_wait_rready", bus.m_axi_rready, 1);
            check("r_wait_no_ack", bus.req_ack, 0);
            step();
        end
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = data;
        bus.m_axi_rresp  = resp;
        bus.m_axi_rlast  = 1'b1;
        step();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
        check("ack", bus.req_ack, 1);
        check("ack_data", bus.req_data, data);
        check("ack_rready_off", bus.m_axi_rready, 0);
        step();
        check("hold_ack_off", bus.req_ack, 0);
        check("hold_busy", busy, 1);
        check("hold_data", bus.req_data, data);
        if (!keep_vld) bus.req_valid = 1'b0;
        step();
        check("idle_busy", busy, 0);
        check("idle_no_ar", bus.m_axi_arvalid, 0);
        bus.req_valid = 1'b0;
    endtask

    int ack0, ar0;

    initial begin
        bus.req_addr      = '0;
        bus.req_valid     = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rvalid  = 1'b0;

        step();
        step();
        check("rst_arvalid", bus.m_axi_arvalid, 0);
        check("rst_rready", bus.m_axi_rready, 0);
        check("rst_ack", bus.req_ack, 0);
        check("rst_data", bus.req_data, 0);
        check("rst_araddr", bus.m_axi_araddr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_cnt, 0);
        check("arlen", bus.m_axi_arlen, 8'h00);
        check("arsize", bus.m_axi_arsize, 3'b100);
        check("arburst", bus.m_axi_arburst, 2'b01);
        rst_n = 1'b1;
        step();

        // Single read, unaligned address, ack at cycle 3
        rd(33'h0_0000_1237, 33'h0_0000_1230, {16{8'hA5}}, 2'b00, 0, 0, 1'b0);

        // AR back-pressure for 7 cycles, ack at cycle 10
        rd(33'h0_0000_2004, 33'h0_0000_2000, {4{32'h1357_9BDF}}, 2'b00, 7, 0, 1'b0);
        check("err_after_ok", err_cnt, 0);

        // Asynchronous reset while AR is pending
        bus.req_addr  = 33'h0_0000_3000;
        bus.req_valid = 1'b1;
        step();
        check("mid_arvalid", bus.m_axi_arvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", bus.m_axi_arvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", bus.req_data, 0);
        bus.req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", busy, 0);

        // Error response still returns data; valid held through HOLD is ignored
        rd(33'h0_0000_4018, 33'h0_0000_4010, {4{32'hCAFE_F00D}}, 2'b10, 0, 2, 1'b1);
        check("err_cnt_1", err_cnt, 1);

        // Abort in R: beat consumed, no ack, req_data kept
        bus.req_addr  = 33'h0_0000_5000;
        bus.req_valid = 1'b1;
        step();
        bus.m_axi_arready = 1'b1;
        step();
        bus.m_axi_arready = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("abort_rready", bus.m_axi_rready, 1);
        check("abort_no_ack_r", bus.req_ack, 0);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.m_axi_rdata  = {4{32'hDEAD_BEEF}};
        step();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        check("abort_no_ack", bus.req_ack, 0);
        check("abort_consumed", bus.m_axi_rready, 0);
        check("abort_data_kept", bus.req_data, {4{32'hCAFE_F00D}});
        bus.req_valid = 1'b0;
        step();
        check("abort_no_ack2", bus.req_ack, 0);
        step();
        check("abort_idle", busy, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_idle_noop", busy, 0);
        rd(33'h0_0000_6000, 33'h0_0000_6000, {4{32'h0BAD_CAFE}}, 2'b00, 0, 0, 1'b0);
        check("err_after_abort", err_cnt, 1);

        // R-channel beat withheld for 40 cycles
        bus.req_addr  = 33'h0_0000_7000;
        bus.req_valid = 1'b1;
        step();
        bus.m_axi_arready = 1'b1;
        step();
        bus.m_axi_arready = 1'b0;
`ifdef IC_DMA_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            check("tmo_wait_ack", bus.req_ack, 0);
            step();
        end
        check("tmo_r16_ack", bus.req_ack, 0);
        step();
        check("tmo_ack", bus.req_ack, 1);
        check("tmo_data", bus.req_data, 0);
        check("tmo_err", err_cnt, 2);
        check("tmo_drain_rready", bus.m_axi_rready, 1);
        bus.req_valid = 1'b0;
        for (int k = 17; k < 40; k++) begin
            step();
            check("drain_no_ack", bus.req_ack, 0);
            check("drain_rready", bus.m_axi_rready, 1);
        end
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.m_axi_rdata  = {4{32'h7777_7777}};
        step();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        check("drain_done_rready", bus.m_axi_rready, 0);
        check("drain_discard_ack", bus.req_ack, 0);
        check("drain_discard_data", bus.req_data, 0);
        check("drain_err", err_cnt, 2);
        step();
        check("drain_idle", busy, 0);
`else
        for (int k = 0; k < 40; k++) begin
            check("nowdog_no_ack", bus.req_ack, 0);
            check("nowdog_rready", bus.m_axi_rready, 1);
            step();
        end
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.m_axi_rdata  = {4{32'h7777_7777}};
        step();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        check("nowdog_ack", bus.req_ack, 1);
        check("nowdog_data", bus.req_data, {4{32'h7777_7777}});
        bus.req_valid = 1'b0;
        step();
        step();
        check("nowdog_idle", busy, 0);
        check("nowdog_err", err_cnt, 1);
`endif

        // Cache-style stream of 512 consecutive lines
        ack0 = ack_cnt;
        ar0  = ar_cnt;
        for (int i = 0; i < 512; i++) begin
            rd(33'h1_0000_0008 + 33'(16 * i), 33'h1_0000_0000 + 33'(16 * i),
               {4{32'(i) ^ 32'h5A5A_0000}}, 2'b00, 0, 0, 1'b0);
        end
        check("stream_acks", 128'(ack_cnt - ack0), 512);
        check("stream_ars", 128'(ar_cnt - ar0), 512);
        check("addr_monotonic", 128'(mono_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
